// File: rtl/lfsr_am_datapath_pkg.sv
// Shared defaults, the stored entry layout and the LFSR step function
// for the LFSR-addressed associative memory.
package lfsr_am_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_KEY_W  = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 2**DEF_ADDR_W - 1;

  localparam logic [DEF_ADDR_W-1:0] DEF_SEED = 4'b0001;
  localparam logic [DEF_ADDR_W-1:0] DEF_TAPS = 4'b1100;

  typedef struct packed {
    logic [DEF_KEY_W-1:0]  key;
    logic [DEF_DATA_W-1:0] value;
  } entry_t;

  // Fibonacci step: shift left, feed back parity of the tapped bits.
  function automatic logic [DEF_ADDR_W-1:0] lfsr_next(
    input logic [DEF_ADDR_W-1:0] q,
    input logic [DEF_ADDR_W-1:0] taps
  );
    return {q[DEF_ADDR_W-2:0], ^(q & taps)};
  endfunction

endpackage

// File: rtl/lfsr_am_datapath_if.sv
// Control handshake and user data bus between the control FSM (master)
// and the associative-memory datapath (slave).
interface lfsr_am_datapath_if
  import lfsr_am_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int KEY_W  = DEF_KEY_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              WR;
  logic              RD;
  logic              Temp_Trigger;
  logic              LFSR_Enable;
  logic              LFSR_Reset;
  logic              Data_Compare_Enable;
  logic [KEY_W-1:0]  Key_In;
  logic [DATA_W-1:0] Value_In;

  logic              Compare_Found;
  logic              Hit;
  logic              Miss;
  logic [DATA_W-1:0] Data_Out;
  logic [ADDR_W-1:0] Match_Addr;
  logic [ADDR_W-1:0] Entry_Count;
  logic              Full;
  logic              Write_Overflow;

  modport master (
    output WR, RD, Temp_Trigger, LFSR_Enable, LFSR_Reset, Data_Compare_Enable,
           Key_In, Value_In,
    input  Compare_Found, Hit, Miss, Data_Out, Match_Addr, Entry_Count, Full,
           Write_Overflow
  );

  modport slave (
    input  WR, RD, Temp_Trigger, LFSR_Enable, LFSR_Reset, Data_Compare_Enable,
           Key_In, Value_In,
    output Compare_Found, Hit, Miss, Data_Out, Match_Addr, Entry_Count, Full,
           Write_Overflow
  );

endinterface

// File: rtl/lfsr_am_datapath_lfsr_gen.sv
// Loadable Fibonacci LFSR used as an address pointer. load wins over step.
module lfsr_gen
  import lfsr_am_pkg::*;
#(
  parameter int                ADDR_W = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] SEED   = DEF_SEED,
  parameter logic [ADDR_W-1:0] TAPS   = DEF_TAPS
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              load,
  input  logic              step,
  output logic [ADDR_W-1:0] q
);

  // Pointer register: reload to SEED or advance one LFSR state.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)  q <= SEED;
    else if (load) q <= SEED;
    else if (step) q <= lfsr_next(q, TAPS);
  end

endmodule

// File: rtl/lfsr_am_datapath.sv
// Key/value store written at successive LFSR addresses and searched by a
// second LFSR. The done flag is sticky so the control FSM always sees an
// end-of-search, whether it hit, missed or the store was empty.
module lfsr_am_datapath
  import lfsr_am_pkg::*;
#(
  parameter int                ADDR_W = DEF_ADDR_W,
  parameter int                KEY_W  = DEF_KEY_W,
  parameter int                DATA_W = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] SEED   = DEF_SEED,
  parameter logic [ADDR_W-1:0] TAPS   = DEF_TAPS
) (
  input  logic               Clock,
  input  logic               Reset_n,
  lfsr_am_datapath_if.slave  bus
);

  localparam int                DEPTH   = 2**ADDR_W - 1;
  localparam logic [ADDR_W-1:0] DEPTH_V = ADDR_W'(DEPTH);

  logic [ADDR_W-1:0]    wr_addr, srch_addr, step_cnt, entry_cnt;
  logic [KEY_W-1:0]     key_reg;
  logic [2**ADDR_W-1:0] valid;
  entry_t               mem [0:2**ADDR_W-1];
  entry_t               cur_entry;

  logic              found, hit, miss, overflow;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] match_addr;

  logic full, do_write, key_hit, search_act, exhausted, srch_load, srch_step;

  assign full      = (entry_cnt == DEPTH_V);
  assign do_write  = bus.WR && !full;
  assign cur_entry = mem[srch_addr];
  assign key_hit   = valid[srch_addr] && (cur_entry.key == key_reg);
  assign exhausted = (step_cnt == DEPTH_V);

  // Any higher-priority control in the same cycle suppresses the compare.
  assign search_act = !bus.WR && !bus.Temp_Trigger && !bus.LFSR_Reset && !found &&
                      bus.RD && bus.Data_Compare_Enable;
  assign srch_load  = bus.WR || bus.Temp_Trigger || bus.LFSR_Reset;
  assign srch_step  = search_act && !exhausted && !key_hit && bus.LFSR_Enable;

  lfsr_gen #(.ADDR_W(ADDR_W), .SEED(SEED), .TAPS(TAPS)) u_wr_ptr (
    .Clock(Clock), .Reset_n(Reset_n), .load(1'b0), .step(do_write), .q(wr_addr)
  );

  lfsr_gen #(.ADDR_W(ADDR_W), .SEED(SEED), .TAPS(TAPS)) u_srch_ptr (
    .Clock(Clock), .Reset_n(Reset_n), .load(srch_load), .step(srch_step), .q(srch_addr)
  );

  // Entry storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge Clock) begin
    if (do_write) mem[wr_addr] <= '{key: bus.Key_In, value: bus.Value_In};
  end

  // Valid bits, occupancy count and the dropped-write pulse.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      valid     <= '0;
      entry_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= bus.WR && full;
      if (do_write) begin
        valid[wr_addr] <= 1'b1;
        entry_cnt      <= entry_cnt + 1'b1;
      end
    end
  end

  // Addresses visited so far; freezes with the search pointer once done.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)       step_cnt <= '0;
    else if (srch_load) step_cnt <= '0;
    else if (srch_step) step_cnt <= step_cnt + 1'b1;
  end

  // Search key capture and sticky result flags.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      key_reg    <= '0;
      found      <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      data_out   <= '0;
      match_addr <= '0;
    end else if (bus.WR) begin
      found <= 1'b0;
      hit   <= 1'b0;
      miss  <= 1'b0;
    end else if (bus.Temp_Trigger) begin
      key_reg <= bus.Key_In;
      found   <= 1'b0;
      hit     <= 1'b0;
      miss    <= 1'b0;
    end else if (search_act) begin
      if (exhausted) begin
        found    <= 1'b1;
        miss     <= 1'b1;
        data_out <= '0;
      end else if (key_hit) begin
        found      <= 1'b1;
        hit        <= 1'b1;
        data_out   <= cur_entry.value;
        match_addr <= srch_addr;
      end
    end
  end

  assign bus.Compare_Found  = found;
  assign bus.Hit            = hit;
  assign bus.Miss           = miss;
  assign bus.Data_Out       = data_out;
  assign bus.Match_Addr     = match_addr;
  assign bus.Entry_Count    = entry_cnt;
  assign bus.Full           = full;
  assign bus.Write_Overflow = overflow;

endmodule
